// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - RV32I encoding constants, mnemonic and loader state types
package instr_encoder_loader_pkg;

    // Opcodes of the formats the loader can produce
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // addi x0,x0,0 stands in for any rejected bundle so the program keeps its layout
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    // Mnemonic codes shared with the decoder's alu_control table; 9-15 are illegal
    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_LW   = 4'd5,
        MN_ADDI = 4'd6,
        MN_SW   = 4'd7,
        MN_BEQ  = 4'd8
    } mnem_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A 13-bit operand fits a 12-bit signed I/S immediate when its top two bits agree
    function automatic logic imm12_fits(input logic [12:0] imm);
        return imm[12] == imm[11];
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - operand bundle stream in, imem write bus out
interface instr_encoder_loader_if #(
    parameter int AW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [3:0]    in_mnem;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [12:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport master (
        output in_valid, in_last, in_mnem, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_last, in_mnem, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader_encode.sv
// rtl/instr_encoder_loader_encode.sv - combinational operand fields to RV32I word
module instr_encoder_loader_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        bad
);

    // Assemble the word per format; anything unencodable becomes NOP and flags bad
    always_comb begin
        word = NOP_WORD;
        bad  = 1'b0;
        case (mnem)
            MN_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_R};
            MN_SUB:  word = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OP_R};
            MN_AND:  word = {F7_BASE, rs2, rs1, F3_AND,     rd, OP_R};
            MN_OR:   word = {F7_BASE, rs2, rs1, F3_OR,      rd, OP_R};
            MN_SLT:  word = {F7_BASE, rs2, rs1, F3_SLT,     rd, OP_R};
            MN_LW: begin
                if (imm12_fits(imm)) word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
                else                 bad  = 1'b1;
            end
            MN_ADDI: begin
                if (imm12_fits(imm)) word = {imm[11:0], rs1, F3_ADDI, rd, OP_IMM};
                else                 bad  = 1'b1;
            end
            MN_SW: begin
                if (imm12_fits(imm)) word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
                else                 bad  = 1'b1;
            end
            MN_BEQ: begin
                // Branch offsets are halfword aligned; an odd offset cannot be encoded
                if (!imm[0]) word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
                else         bad  = 1'b1;
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes operand bundles and loads them sequentially into imem
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instr_encoder_loader_if.slave bus,
    output logic                  cpu_run,
    output logic                  err,
    output logic [AW:0]           count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          cpu_run_q, cpu_run_d;
    logic          imem_we_q, imem_we_d;
    logic [AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]   imem_wdata_q, imem_wdata_d;

    logic          full;
    logic          ready;
    logic          take;
    logic [31:0]   enc_word;
    logic          enc_bad;

    instr_encoder_loader_encode u_encode (
        .mnem (bus.in_mnem),
        .rd   (bus.in_rd),
        .rs1  (bus.in_rs1),
        .rs2  (bus.in_rs2),
        .imm  (bus.in_imm),
        .word (enc_word),
        .bad  (enc_bad)
    );

    assign full = (count_q >= DEPTH_C);
    // start wins over a simultaneous handshake: that bundle is dropped
    assign take = bus.in_valid && ready && !start;

    // State register and all registered datapath outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            err_q        <= 1'b0;
            cpu_run_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            err_q        <= err_d;
            cpu_run_q    <= cpu_run_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    // Next state: start (re)enters LOAD from anywhere, last accepted bundle ends the load
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: if (take && bus.in_last) state_d = ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs: accept only while loading and imem still has room
    always_comb begin
        ready = (state_q == ST_LOAD) && !full;
    end

    // Write stage, word counter, sticky error and delayed run release
    always_comb begin
        count_d      = count_q;
        err_d        = err_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        // cpu_run follows DONE one cycle late so it rises after the final write is presented
        cpu_run_d    = (state_q == ST_DONE) && !start;
        if (start) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (take) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = count_q[AW-1:0];
            imem_wdata_d = enc_word;
            count_d      = count_q + 1'b1;
            if (enc_bad) err_d = 1'b1;
        end else if ((state_q == ST_LOAD) && full && bus.in_valid) begin
            // Host kept offering words after imem filled: program is truncated
            err_d = 1'b1;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_run        = cpu_run_q;
    assign err            = err_q;
    assign count          = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
module tb_instr_encoder_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start4;
    logic       cpu_run, err, cpu_run4, err4;
    logic [6:0] count;
    logic [2:0] count4;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_cnt = 0;
    int obs_rd = 0;

    logic [37:0] exp_q[$];
    logic [37:0] obs_q[$];
    logic [33:0] obs4_q[$];

    always #5 clk = ~clk;

    instr_encoder_loader_if #(.AW(6)) bus  ();
    instr_encoder_loader_if #(.AW(2)) bus4 ();

    instr_encoder_loader #(.DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_run(cpu_run), .err(err), .count(count)
    );

    instr_encoder_loader #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .bus(bus4),
        .cpu_run(cpu_run4), .err(err4), .count(count4)
    );

    always @(negedge clk) begin
        if (bus.imem_we)  obs_q.push_back({bus.imem_addr, bus.imem_wdata});
        if (bus4.imem_we) obs4_q.push_back({bus4.imem_addr, bus4.imem_wdata});
    end

    function automatic logic [32:0] tb_enc(input logic [3:0] m, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [12:0] imm);
        logic [31:0] w;
        logic        b;
        w = 32'h00000013;
        b = 1'b0;
        case (m)
            4'd0: w = {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            4'd1: w = {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            4'd2: w = {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
            4'd3: w = {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            4'd4: w = {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
            4'd5: if (imm[12] != imm[11]) b = 1'b1; else w = {imm[11:0], rs1, 3'd2, rd, 7'h03};
            4'd6: if (imm[12] != imm[11]) b = 1'b1; else w = {imm[11:0], rs1, 3'd0, rd, 7'h13};
            4'd7: if (imm[12] != imm[11]) b = 1'b1; else w = {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
            4'd8: if (imm[0]) b = 1'b1; else w = {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'h63};
            default: b = 1'b1;
        endcase
        return {b, w};
    endfunction

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tb_cnt = 0;
    endtask

    task automatic send(input logic [3:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm, input logic last,
                        input logic [31:0] exp_word);
        bit got = 0;
        bus.in_mnem = m; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_imm = imm; bus.in_last = last; bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                got = 1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL handshake: in_ready never seen for mnem %0d (required within 20 cycles)", m);
        end else begin
            exp_q.push_back({tb_cnt[5:0], exp_word});
            tb_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_mnem = '0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
        bus4.in_valid = 1'b0; bus4.in_last = 1'b0; bus4.in_mnem = '0;
        bus4.in_rd = '0; bus4.in_rs1 = '0; bus4.in_rs2 = '0; bus4.in_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.imem_we, cpu_run, err} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: ready/we/run/err=%b required 0000", {bus.in_ready, bus.imem_we, cpu_run, err});
        end
        n_cmp++;
        if ({bus.imem_addr, bus.imem_wdata, count} !== 45'd0) begin
            n_bad++;
            $display("FAIL reset_values: addr=%h wdata=%h count=%0d required 0", bus.imem_addr, bus.imem_wdata, count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus4.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_ready: in_ready=%b/%b required 0 before start", bus.in_ready, bus4.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [37:0] e, o;
        start_pulse();
        send(4'd6, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, 32'h00500093);
        send(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h002081B3);
        send(4'd1, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h402081B3);
        n_cmp++;
        if (cpu_run !== 1'b0) begin
            n_bad++;
            $display("FAIL run_early: cpu_run=%b required 0 while last word is written", cpu_run);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (cpu_run !== 1'b1 || err !== 1'b0 || count !== 7'd3) begin
            n_bad++;
            $display("FAIL basic_end: run=%b err=%b count=%0d required 1 0 3", cpu_run, err, count);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_writes: %0d writes required %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL basic_word: addr/data %h/%h required %h/%h", o[37:32], o[31:0], e[37:32], e[31:0]);
            end
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    task automatic test_ldst_branch();
        logic [37:0] e, o;
        start_pulse();
        n_cmp++;
        if (cpu_run !== 1'b0 || count !== 7'd0) begin
            n_bad++;
            $display("FAIL restart_done: run=%b count=%0d required 0 0", cpu_run, count);
        end
        send(4'd5, 5'd2, 5'd0, 5'd0, 13'd8, 1'b0, 32'h00802103);
        send(4'd7, 5'd0, 5'd0, 5'd2, 13'd4, 1'b0, 32'h00202223);
        send(4'd8, 5'd0, 5'd1, 5'd2, -13'sd4, 1'b1, 32'hFE208EE3);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_bad++;
            $display("FAIL ldst_writes: %0d writes required %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL ldst_word: addr/data %h/%h required %h/%h", o[37:32], o[31:0], e[37:32], e[31:0]);
            end
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    task automatic test_reject();
        logic [37:0] e, o;
        start_pulse();
        send(4'd12, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, 32'h00000013);
        send(4'd6, 5'd1, 5'd0, 5'd0, 13'h0900, 1'b0, 32'h00000013);
        send(4'd8, 5'd0, 5'd1, 5'd2, 13'd3, 1'b1, 32'h00000013);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (err !== 1'b1 || count !== 7'd3 || cpu_run !== 1'b1) begin
            n_bad++;
            $display("FAIL reject_end: err=%b count=%0d run=%b required 1 3 1", err, count, cpu_run);
        end
        n_cmp++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_bad++;
            $display("FAIL reject_writes: %0d writes required %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reject_word: addr/data %h/%h required %h/%h", o[37:32], o[31:0], e[37:32], e[31:0]);
            end
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    task automatic test_full();
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        bus4.in_mnem = 4'd6; bus4.in_rd = 5'd1; bus4.in_rs1 = 5'd0; bus4.in_imm = 13'd7;
        bus4.in_last = 1'b0; bus4.in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (bus4.in_ready !== 1'b0 || err4 !== 1'b1 || cpu_run4 !== 1'b0 || count4 !== 3'd4) begin
            n_bad++;
            $display("FAIL full_state: ready=%b err=%b run=%b count=%0d required 0 1 0 4", bus4.in_ready, err4, cpu_run4, count4);
        end
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (obs4_q.size() !== 4) begin
            n_bad++;
            $display("FAIL full_writes: %0d writes required 4", obs4_q.size());
        end
        for (int i = 0; i < obs4_q.size() && i < 4; i++) begin
            n_cmp++;
            if (obs4_q[i] !== {i[1:0], 32'h00700093}) begin
                n_bad++;
                $display("FAIL full_word: entry %0d = %h required %h", i, obs4_q[i], {i[1:0], 32'h00700093});
            end
        end
    endtask

    task automatic test_random();
        logic [37:0] e, o;
        logic [32:0] r;
        logic [3:0]  m;
        logic [4:0]  rd, rs1, rs2;
        logic [12:0] imm;
        logic        exp_err;
        start_pulse();
        bus.in_mnem = 4'd0; bus.in_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.imem_we !== 1'b0 || count !== 7'd0) begin
            n_bad++;
            $display("FAIL start_priority: we=%b count=%0d required 0 0", bus.imem_we, count);
        end
        exp_err = 1'b0;
        for (int k = 0; k < 12; k++) begin
            m   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            imm = 13'($urandom);
            if ($urandom_range(0, 2) != 0) imm = {imm[11], imm[11:1], 1'b0};
            r = tb_enc(m, rd, rs1, rs2, imm);
            exp_err = exp_err | r[32];
            send(m, rd, rs1, rs2, imm, k == 11, r[31:0]);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (err !== exp_err || count !== 7'd12 || cpu_run !== 1'b1) begin
            n_bad++;
            $display("FAIL random_end: err=%b count=%0d run=%b required %b 12 1", err, count, cpu_run, exp_err);
        end
        n_cmp++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_bad++;
            $display("FAIL random_writes: %0d writes required %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random_word: addr/data %h/%h required %h/%h", o[37:32], o[31:0], e[37:32], e[31:0]);
            end
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    task automatic test_midload_reset();
        logic [37:0] e, o;
        start_pulse();
        send(4'd15, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, 32'h00000013);
        send(4'd6, 5'd4, 5'd4, 5'd0, 13'd1, 1'b0, 32'h00120213);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({bus.imem_we, bus.in_ready, err, cpu_run} !== 4'b0 || count !== 7'd0) begin
            n_bad++;
            $display("FAIL midload_reset: we/ready/err/run=%b count=%0d required 0000 0", {bus.imem_we, bus.in_ready, err, cpu_run}, count);
        end
        start_pulse();
        send(4'd2, 5'd5, 5'd6, 5'd7, 13'd0, 1'b1, 32'h007372B3);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (err !== 1'b0 || count !== 7'd1 || cpu_run !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_end: err=%b count=%0d run=%b required 0 1 1", err, count, cpu_run);
        end
        n_cmp++;
        if (obs_q.size() - obs_rd !== exp_q.size()) begin
            n_bad++;
            $display("FAIL reload_writes: %0d writes required %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reload_word: addr/data %h/%h required %h/%h", o[37:32], o[31:0], e[37:32], e[31:0]);
            end
        end
        exp_q.delete(); obs_rd = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ldst_branch();
        test_reject();
        test_full();
        test_random();
        test_midload_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
